// File: rtl/i2s_tx.sv
// i2s_tx: serializes stereo 16-bit samples as a Philips I2S stream (BCLK, LRCLK, SDATA) to an external DAC.
// Latency: a captured sample goes out in the next frame; if the strobe lands on a frame boundary, it goes out in that frame.
// Backpressure: none. Samples are double-buffered. A second strobe before transmission overwrites the first and sets the sticky overrun flag.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   samp_clk     one-cycle sample strobe; sample_l/sample_r are valid while it is high
//   sample_l/r   two's-complement channel samples (mono sources drive both)
//   bclk         bit clock, clk / (2*CLK_DIV)
//   lrclk        word select, 0 = left, 1 = right, leads each channel MSB by one BCLK
//   sdata        serial data, MSB first, changes on the BCLK falling edge
//   frame_start  one-cycle pulse when the shift word is loaded
//   overrun      sticky: a held sample was overwritten before it was sent
module i2s_tx #(
  parameter int CLK_DIV = 32,
  parameter int WORD_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              samp_clk,
  input  logic [WORD_W-1:0] sample_l,
  input  logic [WORD_W-1:0] sample_r,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              overrun
);

  localparam int FRAME_W = 2 * WORD_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(FRAME_W - 2);

  // Divider and bit position
  logic [DIV_W-1:0]   r_div_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;

  // Sample double buffer: holding registers feed the shift word at each frame boundary
  logic [WORD_W-1:0]  r_hold_l;
  logic [WORD_W-1:0]  r_hold_r;
  logic [FRAME_W-1:0] r_shift;
  logic               r_pending;

  // Registered outputs
  logic               r_bclk;
  logic               r_lrclk;
  logic               r_sdata;
  logic               r_frame_start;
  logic               r_overrun;

  logic               w_div_wrap;
  logic               w_fall;
  logic [BIT_W-1:0]   w_bit_next;
  logic               w_boundary;
  logic [FRAME_W-1:0] w_load_word;
  logic [BIT_W-1:0]   w_bit_idx;
  logic               w_tx_bit;
  logic               w_lr_next;

  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  // A falling edge is the divider wrap while bclk is currently high
  assign w_fall     = w_div_wrap & r_bclk;
  assign w_bit_next = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
  assign w_boundary = w_fall & (w_bit_next == '0);

  // A strobe in the boundary cycle bypasses the holding registers, so it goes out in this frame
  assign w_load_word = samp_clk ? {sample_l, sample_r} : {r_hold_l, r_hold_r};

  // Bit n of the frame carries shift-word bit (FRAME_W-1-n); at the boundary use the word being loaded
  assign w_bit_idx = BIT_LAST - w_bit_next;
  assign w_tx_bit  = w_boundary ? w_load_word[FRAME_W-1] : r_shift[w_bit_idx];

  // lrclk switches one bit early, on the last bit of the previous channel
  assign w_lr_next = (w_bit_next >= LR_LO) && (w_bit_next <= LR_HI);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= BIT_LAST;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_shift       <= '0;
      r_pending     <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;

      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_sdata   <= w_tx_bit;
        r_lrclk   <= w_lr_next;
      end

      if (w_boundary) begin
        r_shift       <= w_load_word;
        r_frame_start <= 1'b1;
      end

      // Holding registers always track the latest strobe, so a slow source repeats its last word
      if (samp_clk) begin
        r_hold_l <= sample_l;
        r_hold_r <= sample_r;
      end

      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (samp_clk) begin
        r_pending <= 1'b1;
        if (r_pending) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign sdata       = r_sdata;
  assign frame_start = r_frame_start;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx with CLK_DIV=4, WORD_W=16.
// Latency: expected frames are queued at strobe time and compared when a full frame has been received.
// Backpressure: not applicable. The bench drives strobes at chosen offsets from frame boundaries.
module tb_i2s_tx;

  localparam int CLK_DIV = 4;
  localparam int WORD_W  = 16;
  localparam int FRAME_CLKS = 2 * WORD_W * 2 * CLK_DIV;   // 256

  logic              clk = 1'b0;
  logic              rst;
  logic              samp_clk;
  logic [WORD_W-1:0] sample_l;
  logic [WORD_W-1:0] sample_r;
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic              frame_start;
  logic              overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];

  i2s_tx #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .samp_clk    (samp_clk),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Called at posedge+#1; the strobe is sampled on the next edge
  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    samp_clk = 1'b1;
    sample_l = l;
    sample_r = r;
    @(posedge clk); #1;
    samp_clk = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    if (!seen) check("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_q_empty();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) check("q_timeout", exp_q.size(), 32'd0);
  endtask

  // Reset for three cycles, release, then check the divider and frame_start timing
  task automatic run_reset_timing(input bit do_strobe);
    rst = 1'b0;
    samp_clk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_outs", {27'd0, bclk, lrclk, sdata, frame_start, overrun}, 32'd0);
    end
    rst = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      check("bclk_t", bclk, ((c / CLK_DIV) % 2 == 1) ? 32'd1 : 32'd0);
      check("fs_t", frame_start, (c == 2 * CLK_DIV) ? 32'd1 : 32'd0);
      if (c == 4) begin
        if (do_strobe) begin
          exp_q.push_back(32'hA5C3_0F0F);
          strobe(16'hA5C3, 16'h0F0F);   // sampled at cycle 5, consumes the c=5 edge
          check("bclk_t", bclk, 32'd1);
          check("fs_t", frame_start, 32'd0);
          c++;
        end else begin
          exp_q.push_back(32'h0000_0000);
        end
      end
    end
  endtask

  // Receiver: captures sdata/lrclk on bclk rising edges, framed by frame_start.
  // A frame is checked only if an expectation was queued before it started.
  initial begin
    bit prev_b;
    bit active;
    bit chkf;
    int nb;
    logic [31:0] dw;
    logic [31:0] lw;
    logic [31:0] e;
    prev_b = 1'b0;
    active = 1'b0;
    chkf   = 1'b0;
    nb     = 0;
    dw     = '0;
    lw     = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        active = 1'b0;
        prev_b = 1'b0;
      end else begin
        if (frame_start === 1'b1) begin
          active = 1'b1;
          nb     = 0;
          chkf   = (exp_q.size() > 0);
        end
        if (active && bclk === 1'b1 && !prev_b) begin
          dw = {dw[30:0], sdata};
          lw = {lw[30:0], lrclk};
          nb++;
          if (nb == 32) begin
            active = 1'b0;
            if (chkf && exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("frame_data", dw, e);
              check("frame_lrclk", lw, 32'h0001_FFFE);
            end
          end
        end
        prev_b = (bclk === 1'b1);
      end
    end
  end

  initial begin
    int t0;
    rst      = 1'b0;
    samp_clk = 1'b0;
    sample_l = '0;
    sample_r = '0;

    // Reset timing plus a single frame
    run_reset_timing(1'b1);
    wait_q_empty();
    check("ovr_single", overrun, 32'd0);

    // One strobe, three repeated frames, frame period
    wait_fs();
    t0 = cyc;
    repeat (19) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h8000_0001);
    strobe(16'h8000, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      wait_fs();
      check("fs_period", cyc - t0, FRAME_CLKS);
      t0 = cyc;
    end
    wait_q_empty();
    check("ovr_repeat", overrun, 32'd0);

    // Strobe exactly on the frame-boundary cycle
    wait_fs();
    repeat (FRAME_CLKS - 1) @(posedge clk);
    #1;
    exp_q.push_back(32'h7FFF_7FFF);
    exp_q.push_back(32'h7FFF_7FFF);
    samp_clk = 1'b1;
    sample_l = 16'h7FFF;
    sample_r = 16'h7FFF;
    @(posedge clk); #1;
    samp_clk = 1'b0;
    check("coinc_fs", frame_start, 32'd1);
    wait_q_empty();
    check("ovr_coinc", overrun, 32'd0);

    // Two strobes within one frame
    wait_fs();
    repeat (9) @(posedge clk);
    #1;
    strobe(16'h1111, 16'h1111);
    check("ovr_first", overrun, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    exp_q.push_back(32'h2222_2222);
    strobe(16'h2222, 16'h2222);
    check("ovr_set", overrun, 32'd1);
    wait_q_empty();
    check("ovr_sticky", overrun, 32'd1);
    wait_fs();
    wait_fs();
    check("ovr_sticky2", overrun, 32'd1);

    // Reset at bit 10 of a frame, then the timing restarts from scratch
    wait_fs();
    repeat (10 * 2 * CLK_DIV) @(posedge clk);
    #1;
    run_reset_timing(1'b0);
    wait_q_empty();
    check("ovr_after_rst", overrun, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Downstream stage of the reverb effect: accepts the 16-bit processed sample on each sample strobe and serializes it as a standard Philips I2S stream to the external DAC.
- Generates BCLK and LRCLK from the 200 MHz system clock.
- Double-buffers samples so strobe timing is decoupled from frame timing.
- Mono sources drive the same sample onto both channel inputs.

Parameters:
- CLK_DIV, 32: system clocks per BCLK half-period (BCLK = clk / (2*CLK_DIV)); legal values ≥ 2.
- WORD_W, 16: bits per channel; a frame is 2*WORD_W BCLK periods.

Ports:
- clk  in  1  system clock (200 MHz)
- rst  in  1  synchronous reset, active-low
- samp_clk  in  1  sample strobe, one clk cycle wide
- sample_l  in  WORD_W  left sample, two's complement, valid when samp_clk=1
- sample_r  in  WORD_W  right sample, valid when samp_clk=1
- bclk  out  1  I2S bit clock
- lrclk  out  1  word select, 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- frame_start  out  1  one-cycle pulse when a new frame word is loaded
- overrun  out  1  sticky flag: a sample was overwritten before transmission

Behaviour:
- Reset (rst=0 at a clk edge):
  - bclk, lrclk, sdata, frame_start and overrun are 0.
  - Internal state: div_cnt=0, bit_cnt=2*WORD_W-1, holding regs=0, shift reg=0, pending=0.
  - Reset has priority over all other activity and is honoured mid-frame.
- All outputs are registered. No combinational path from inputs to outputs.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and bclk toggles.
  - The first bclk rise occurs CLK_DIV cycles after reset release; the first fall occurs 2*CLK_DIV cycles after.
- Falling-edge event (the cycle bclk goes 1→0):
  - bit_cnt increments modulo 2*WORD_W; n is the new value.
  - sdata = bit (2*WORD_W-1-n) of the shift word {L,R}.
  - lrclk = 1 when W-1 ≤ n ≤ 2W-2, else 0. This gives the standard I2S one-bit delay: lrclk leads each channel's MSB by one BCLK.
  - sdata, lrclk and bclk all change in the same clk cycle.
- Frame boundary (falling edge where n becomes 0):
  - The shift word loads from the holding registers; sdata takes the new left MSB; frame_start=1 for that cycle only.
  - If pending=0, the holding registers still hold the last sample, so the previous word repeats. This covers frame rate > sample rate.
  - pending clears.
- Sample capture:
  - samp_clk=1 latches sample_l and sample_r into the holding registers and sets pending.
  - If pending is already 1, the holding registers are overwritten and overrun is set. overrun stays 1 until reset.
  - If samp_clk coincides with a frame boundary, the incoming sample bypasses into the shift word and is transmitted in that frame. pending ends at 0 and overrun is not set.
- Receivers sample sdata on the bclk rising edge. Data is stable for CLK_DIV clk cycles either side of that edge.
- samp_clk pulses longer than one cycle are treated as repeated strobes; this is the caller's responsibility.

Test Plan:
- Reset/timing, CLK_DIV=4: hold rst=0 for 3 cycles, then release → all outputs 0 during reset; bclk rises at cycle 4, falls at cycle 8; frame_start=1 at cycle 8 only; bclk period 8 clk thereafter.
- Single frame, CLK_DIV=4: strobe L=16'hA5C3, R=16'h0F0F before cycle 8.
  - Next frame: bits captured on bclk rising edges are A5C3 then 0F0F.
  - lrclk rises on the falling edge carrying L bit 0 and falls on the falling edge carrying R bit 0.
  - overrun=0.
- Repeat/full-scale: strobe L=16'h8000, R=16'h0001 once → three consecutive frames each carry 8000/0001; frame_start pulses every 256 clk (32 bits × 8).
- Overrun: two strobes within one frame, L/R=16'h1111 then 16'h2222 → next frame carries 2222/2222; overrun=1 and stays 1 through later frames.
- Coincidence: strobe L=R=16'h7FFF in exactly the frame-boundary cycle → that same frame transmits 7FFF/7FFF; the following frame repeats it; overrun=0.
- Mid-frame reset: assert rst=0 at bit 10 of a frame → next cycle all outputs 0 and overrun cleared; after release, timing restarts exactly as in the reset/timing scenario.
